// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// controller states, plus the forwarding priority function.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } forward_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } hz_state_t;

    // Memory stage result is newer than writeback, so it wins when both match.
    function automatic forward_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Inc,
    output logic [W-1:0] o_Count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset)
            count_reg <= '0;
        else if (i_Inc && (count_reg != '1))
            count_reg <= count_reg + 1'b1;
    end

    assign o_Count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding,
// load-use and data-memory wait stalls, branch flushes, timeout and perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic [4:0]       i_RdM,
    input  logic [4:0]       i_RdW,
    input  logic             i_ResultSrcE0,
    input  logic             i_RegWriteM,
    input  logic             i_RegWriteW,
    input  logic             i_PCSrcE,
    input  logic             i_MemReqM,
    input  logic             i_MemAckM,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic             o_FlushW,
    output logic             o_MemErr,
    output logic [CNT_W-1:0] o_StallCnt,
    output logic [CNT_W-1:0] o_FlushCnt
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    hz_state_t         state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg;
    logic              mem_stall, load_stall, hold_all;

    logic [4:0]   rs_e [2];
    forward_sel_t fwd_sel [2];

    assign rs_e[0] = i_Rs1E;
    assign rs_e[1] = i_Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = fwd_select(rs_e[gi], i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
        end
    endgenerate

    assign o_ForwardAE = fwd_sel[0];
    assign o_ForwardBE = fwd_sel[1];

    assign mem_stall  = i_MemReqM && !i_MemAckM;
    assign load_stall = i_ResultSrcE0 && (i_RdE != 5'd0) &&
                        ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    assign hold_all   = mem_stall || (state_reg == ERROR);

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_reg || (state_reg == ERROR);
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES)) begin
                    state_next    = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ERROR: state_next = ERROR;
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // A whole-pipe hold freezes a taken branch in Execute; it resolves on release.
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushW = 1'b0;
        if (hold_all) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushW = 1'b1;
        end else begin
            o_StallF = load_stall && !i_PCSrcE;
            o_StallD = load_stall && !i_PCSrcE;
            o_FlushD = i_PCSrcE;
            o_FlushE = load_stall || i_PCSrcE;
        end
    end

    assign o_MemErr = mem_err_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Inc   (o_StallF),
        .o_Count (o_StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Inc   (o_FlushE),
        .o_Count (o_FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters.
module tb_hazard_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [4:0] i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW;
    logic       i_ResultSrcE0, i_RegWriteM, i_RegWriteW, i_PCSrcE, i_MemReqM, i_MemAckM;
    logic [1:0] o_ForwardAE, o_ForwardBE;
    logic       o_StallF, o_StallD, o_StallE, o_StallM, o_FlushD, o_FlushE, o_FlushW, o_MemErr;
    logic [3:0] o_StallCnt, o_FlushCnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D), .i_Rs1E(i_Rs1E), .i_Rs2E(i_Rs2E),
        .i_RdE(i_RdE), .i_RdM(i_RdM), .i_RdW(i_RdW),
        .i_ResultSrcE0(i_ResultSrcE0), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
        .i_PCSrcE(i_PCSrcE), .i_MemReqM(i_MemReqM), .i_MemAckM(i_MemAckM),
        .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
        .o_StallF(o_StallF), .o_StallD(o_StallD), .o_StallE(o_StallE), .o_StallM(o_StallM),
        .o_FlushD(o_FlushD), .o_FlushE(o_FlushE), .o_FlushW(o_FlushW),
        .o_MemErr(o_MemErr), .o_StallCnt(o_StallCnt), .o_FlushCnt(o_FlushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        i_Rs1D = 0; i_Rs2D = 0; i_Rs1E = 0; i_Rs2E = 0;
        i_RdE = 0; i_RdM = 0; i_RdW = 0;
        i_ResultSrcE0 = 0; i_RegWriteM = 0; i_RegWriteW = 0;
        i_PCSrcE = 0; i_MemReqM = 0; i_MemAckM = 0;
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Packs the whole-pipe hold outputs: {StallF,StallD,StallE,StallM,FlushW}.
    function automatic logic [4:0] holds();
        return {o_StallF, o_StallD, o_StallE, o_StallM, o_FlushW};
    endfunction

    initial begin
        idle();
        i_Reset = 1'b0;
        #3;
        chk("rst_stallcnt", o_StallCnt, 0);
        chk("rst_flushcnt", o_FlushCnt, 0);
        chk("rst_memerr", o_MemErr, 0);
        chk("rst_holds", holds(), 0);
        tick();
        i_Reset = 1'b1;

        // Forwarding priority
        i_RdM = 5; i_RegWriteM = 1; i_RdW = 5; i_RegWriteW = 1; i_Rs1E = 5; i_Rs2E = 0;
        #1 chk("fwdA_M", o_ForwardAE, 2'b10);
        chk("fwdB_none", o_ForwardBE, 2'b00);
        i_RdM = 0;
        #1 chk("fwdA_W", o_ForwardAE, 2'b01);
        i_RdW = 0;
        #1 chk("fwdB_rd0", o_ForwardBE, 2'b00);
        i_Rs2E = 9; i_RdW = 9; i_RdM = 9; i_RegWriteM = 0;
        #1 chk("fwdB_W", o_ForwardBE, 2'b01);
        chk("fwdA_rf", o_ForwardAE, 2'b00);
        idle();
        tick();

        // Load-use
        i_ResultSrcE0 = 1; i_RdE = 7; i_Rs2D = 7;
        #1 chk("lu_stall", {o_StallF, o_StallD, o_StallE, o_StallM}, 4'b1100);
        chk("lu_flush", {o_FlushD, o_FlushE, o_FlushW}, 3'b010);
        tick();
        idle();
        #1 chk("lu_after", {o_StallF, o_StallD, o_FlushE}, 0);
        chk("lu_stallcnt", o_StallCnt, 1);
        chk("lu_flushcnt", o_FlushCnt, 1);

        // Branch with load-use: flush wins
        i_ResultSrcE0 = 1; i_RdE = 7; i_Rs1D = 7; i_PCSrcE = 1;
        #1 chk("br_lu_stall", {o_StallF, o_StallD}, 0);
        chk("br_lu_flush", {o_FlushD, o_FlushE}, 2'b11);
        tick();
        idle();
        #1 chk("br_stallcnt", o_StallCnt, 1);
        chk("br_flushcnt", o_FlushCnt, 2);

        // Memory wait: 3 cycles of stall, branch held during wait
        i_MemReqM = 1; i_MemAckM = 0;
        #1 chk("mw_c1", holds(), 5'b11111);
        tick();
        i_PCSrcE = 1;
        #1 chk("mw_c2", holds(), 5'b11111);
        chk("mw_c2_noflush", {o_FlushD, o_FlushE}, 0);
        tick();
        #1 chk("mw_c3", holds(), 5'b11111);
        chk("mw_c3_noflush", {o_FlushD, o_FlushE}, 0);
        tick();
        i_MemAckM = 1;
        #1 chk("mw_rel_holds", holds(), 0);
        chk("mw_rel_flush", {o_FlushD, o_FlushE}, 2'b11);
        chk("mw_stallcnt", o_StallCnt, 4);
        chk("mw_flushcnt", o_FlushCnt, 2);
        tick();
        idle();
        i_MemReqM = 1; i_MemAckM = 1;
        #1 chk("ack_first", holds(), 0);
        chk("mw_flushcnt2", o_FlushCnt, 3);
        tick();

        // Timeout
        idle();
        i_MemReqM = 1; i_MemAckM = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("to_err_early", o_MemErr, 0);
        tick();
        chk("to_err_set", o_MemErr, 1);
        i_MemReqM = 0;
        #1 chk("to_err_holds", holds(), 5'b11111);
        chk("to_err_noflsh", {o_FlushD, o_FlushE}, 0);
        i_Reset = 1'b0;
        #1 chk("to_rst_memerr", o_MemErr, 0);
        chk("to_rst_holds", holds(), 0);
        chk("to_rst_scnt", o_StallCnt, 0);
        chk("to_rst_fcnt", o_FlushCnt, 0);
        tick();
        i_Reset = 1'b1;

        // Saturation
        i_ResultSrcE0 = 1; i_RdE = 7; i_Rs1D = 7;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_mid", o_StallCnt, 14);
        for (int i = 0; i < 6; i++) tick();
        idle();
        #1 chk("sat_stallcnt", o_StallCnt, 15);
        chk("sat_flushcnt", o_FlushCnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/sequencing controller for the 5-stage RV32I core.
- Drives stall/flush controls into the F/D/E/M/W pipeline registers, including the flush input of the Execute-stage register.
- Produces forwarding selects for the Execute operand muxes.
- Adds a data-memory wait state machine with timeout, plus saturating stall/flush performance counters.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive cycles waiting on data-memory ack before error (>=1)
- CNT_W, 32, width of performance counters

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  reset, asynchronous, active-low
- i_Rs1D, i_Rs2D  in  5  source regs in Decode
- i_Rs1E, i_Rs2E  in  5  source regs in Execute
- i_RdE, i_RdM, i_RdW  in  5  dest regs per stage
- i_ResultSrcE0  in  1  instruction in Execute is a load
- i_RegWriteM, i_RegWriteW  in  1  register write enables for Memory and Writeback
- i_PCSrcE  in  1  branch/jump taken in Execute
- i_MemReqM  in  1  load/store active in Memory
- i_MemAckM  in  1  data memory completes access this cycle
- o_ForwardAE, o_ForwardBE  out  2  00 regfile, 10 ALUResultM, 01 ResultW
- o_StallF, o_StallD, o_StallE, o_StallM  out  1  hold stage register
- o_FlushD, o_FlushE, o_FlushW  out  1  clear stage register to bubble
- o_MemErr  out  1  sticky memory timeout error
- o_StallCnt, o_FlushCnt  out  CNT_W  performance counters

Behaviour:
- Reset (async, i_Reset=0): state=RUN, wait counter=0, o_MemErr=0, both counters=0. Combinational outputs follow the RUN rules.
- Forwarding (combinational, all states):
  - o_ForwardAE=10 if i_RegWriteM && i_RdM!=0 && i_RdM==i_Rs1E.
  - Else 01 if i_RegWriteW && i_RdW!=0 && i_RdW==i_Rs1E.
  - Else 00.
  - M has priority over W. Same rules for o_ForwardBE with i_Rs2E.
- memStall = i_MemReqM && !i_MemAckM, combinational in the same cycle.
- loadStall = i_ResultSrcE0 && i_RdE!=0 && (i_RdE==i_Rs1D || i_RdE==i_Rs2D).
- States: RUN, MEM_WAIT, ERROR.
  - RUN, memStall=1: go to MEM_WAIT, wait counter=1.
  - MEM_WAIT, memStall=0 (ack or request dropped): go to RUN, counter=0.
  - MEM_WAIT, counter==TIMEOUT_CYCLES with memStall still 1: go to ERROR.
  - MEM_WAIT otherwise: counter+1.
  - ERROR: absorbing until reset; o_MemErr=1 (registered, asserts the cycle after entry).
- Outputs when memStall=1 or state==ERROR:
  - StallF=StallD=StallE=StallM=1, FlushW=1 (bubble into W).
  - FlushD=FlushE=0: a branch in Execute is held and re-evaluated after release.
  - The load-use condition is subsumed.
- Outputs otherwise:
  - StallF=StallD=loadStall, StallE=StallM=FlushW=0.
  - FlushD=i_PCSrcE.
  - FlushE=loadStall || i_PCSrcE.
  - A branch taken together with a load-use flushes and does not stall: StallF=StallD=0 when i_PCSrcE=1.
- Ack in the first cycle of a request: no stall, state stays RUN.
- Counters:
  - o_StallCnt increments each cycle o_StallF=1.
  - o_FlushCnt increments each cycle o_FlushE=1.
  - Both saturate at 2^CNT_W-1 and are never cleared except by reset.

Decomposition:
- Package hazard_pkg holds:
  - forward_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), shared with the Execute operand muxes.
  - hz_state_t enum (RUN, MEM_WAIT, ERROR).
- One sub-module, sat_counter (parameter W; inputs inc, clk, async reset): instantiated twice for the perf counters.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. With RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Next cycle ResultSrcE0=0 -> all 0. StallCnt=1, FlushCnt=1.
- Branch vs load-use: PCSrcE=1 with the load-use condition -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, Ack low 3 cycles then high -> StallF..M=1 and FlushW=1 for exactly 3 cycles. Branch asserted during the wait -> no flush until release, then FlushD=FlushE=1. State returns to RUN.
- Timeout (TIMEOUT_CYCLES=4): MemReqM=1, Ack never -> ERROR entered after 4 MEM_WAIT cycles, MemErr=1 next cycle, stalls held. Then i_Reset=0 mid-ERROR -> immediate RUN, MemErr=0, counters 0.
- Saturation (CNT_W=4): hold a load-use stall for 20 cycles -> StallCnt stops at 15.
